// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE sequencer: FSM states, mux select encodings,
// pe_resp bit positions and the registered control-output bundle.
package pe_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_BIAS_LD,
    S_BIAS_ADD,
    S_LOAD,
    S_MUL_LD,
    S_MUL,
    S_MUL_WAIT,
    S_ADD,
    S_ADD_WAIT,
    S_ACC_WR,
    S_POOL,
    S_OUT,
    S_DONE
  } state_e;

  localparam logic SEL_ACTN_CONV = 1'b0;
  localparam logic SEL_ACTN_POOL = 1'b1;
  localparam logic SEL_WT_WEIGHT = 1'b0;
  localparam logic SEL_WT_BIAS   = 1'b1;
  localparam logic SEL_ADD_MULT  = 1'b0;
  localparam logic SEL_ADD_BIAS  = 1'b1;
  localparam logic SEL_OUT_ACC   = 1'b0;
  localparam logic SEL_OUT_POOL  = 1'b1;

  localparam int RESP_MUL = 0;
  localparam int RESP_ADD = 1;

  typedef struct packed {
    logic start_rdy;
    logic busy;
    logic in_rdy;
    logic actn_in_sel;
    logic wt_in_sel;
    logic add_in_sel;
    logic pe_out_sel;
    logic acc_clr;
    logic mult_load;
    logic mult_en;
    logic add_en;
    logic acc_wr_en;
    logic of_rf_wr_en;
    logic out_vld;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{start_rdy: 1'b1, default: 1'b0};

  // Control outputs are a pure function of the state being entered, so
  // registering this decode gives glitch-free strobes aligned with the state.
  function automatic ctrl_t decode_ctrl(input state_e s, input logic pool,
                                        input logic load_open);
    ctrl_t c;
    c             = '0;
    c.start_rdy   = (s == S_IDLE);
    c.busy        = (s != S_IDLE);
    c.in_rdy      = (s == S_BIAS_LD) || ((s == S_LOAD) && load_open);
    c.actn_in_sel = (s == S_POOL) ? SEL_ACTN_POOL : SEL_ACTN_CONV;
    c.wt_in_sel   = ((s == S_BIAS_LD) || (s == S_BIAS_ADD)) ? SEL_WT_BIAS : SEL_WT_WEIGHT;
    c.add_in_sel  = (s == S_BIAS_ADD) ? SEL_ADD_BIAS : SEL_ADD_MULT;
    c.pe_out_sel  = ((s == S_OUT) || (s == S_DONE)) && pool ? SEL_OUT_POOL : SEL_OUT_ACC;
    c.acc_clr     = (s == S_CLR);
    c.mult_load   = (s == S_MUL_LD);
    c.mult_en     = (s == S_MUL);
    c.add_en      = (s == S_BIAS_ADD) || (s == S_ADD);
    c.acc_wr_en   = (s == S_ACC_WR);
    c.of_rf_wr_en = (s == S_OUT);
    c.out_vld     = (s == S_DONE);
    return c;
  endfunction

endpackage

// File: rtl/pe_ctrl.sv
// Job sequencer for one PE datapath (conv MAC window or max-pool window).
// Optional watchdog on pe_resp waits: define PE_CTRL_TIMEOUT_EN.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             start_rdy,
  input  logic             cfg_pool,
  input  logic             cfg_bias,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             actn_in_sel,
  output logic             wt_in_sel,
  output logic             add_in_sel,
  output logic             pe_out_sel,
  output logic             if_rf_wr_en,
  output logic             wt_rf_wr_en,
  output logic             of_rf_wr_en,
  output logic             if_rf_rd_en,
  output logic             wt_rf_rd_en,
  output logic             of_rf_rd_en,
  output logic             mult_en,
  output logic             mult_load,
  output logic             add_en,
  output logic             acc_wr_en,
  output logic             acc_clr,
  input  logic [1:0]       pe_resp,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pool_q, pool_d;
  logic             bias_q, bias_d;
  logic             bias_phase_q, bias_phase_d;
  logic             entry_q, entry_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             xfer;

`ifdef PE_CTRL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
`else
  // Keeps the parameter referenced in the build without the watchdog.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
`endif

  assign xfer = in_vld & ctrl_q.in_rdy;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    pool_d       = pool_q;
    bias_d       = bias_q;
    bias_phase_d = bias_phase_q;
`ifdef PE_CTRL_TIMEOUT_EN
    wdog_d       = '0;
    err_d        = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pool_d       = cfg_pool;
          bias_d       = cfg_bias;
          len_d        = cfg_len;
          cnt_d        = '0;
          bias_phase_d = 1'b0;
          state_d      = S_CLR;
        end
      end
      S_CLR: begin
        if (!pool_q && bias_q) begin
          bias_phase_d = 1'b1;
          state_d      = S_BIAS_LD;
        end else begin
          // An empty window skips straight past LOAD.
          state_d = (cnt_q == len_q) ? S_OUT : S_LOAD;
        end
      end
      S_BIAS_LD:  if (xfer) state_d = S_BIAS_ADD;
      S_BIAS_ADD: state_d = S_ADD_WAIT;
      S_LOAD: begin
        if (cnt_q == len_q) state_d = S_OUT;
        else if (xfer)      state_d = pool_q ? S_POOL : S_MUL_LD;
      end
      S_MUL_LD:   state_d = S_MUL;
      S_MUL:      state_d = S_MUL_WAIT;
      // Done flags may still be stale from the previous op in the entry cycle.
      S_MUL_WAIT: if (!entry_q && pe_resp[RESP_MUL]) state_d = S_ADD;
      S_ADD:      state_d = S_ADD_WAIT;
      S_ADD_WAIT: if (!entry_q && pe_resp[RESP_ADD]) state_d = S_ACC_WR;
      S_ACC_WR: begin
        if (bias_phase_q) bias_phase_d = 1'b0;
        else              cnt_d        = cnt_q + 1'b1;
        state_d = (cnt_d == len_q) ? S_OUT : S_LOAD;
      end
      S_POOL: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == len_q) ? S_OUT : S_LOAD;
      end
      S_OUT:  state_d = S_DONE;
      S_DONE: if (out_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef PE_CTRL_TIMEOUT_EN
    // A response arriving on the last allowed cycle still wins over the abort.
    if (((state_q == S_MUL_WAIT) || (state_q == S_ADD_WAIT)) && (state_d == state_q)) begin
      if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif

    entry_d = (state_d != state_q);
    ctrl_d  = decode_ctrl(state_d, pool_d, cnt_d != len_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      pool_q       <= 1'b0;
      bias_q       <= 1'b0;
      bias_phase_q <= 1'b0;
      entry_q      <= 1'b0;
      ctrl_q       <= CTRL_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      pool_q       <= pool_d;
      bias_q       <= bias_d;
      bias_phase_q <= bias_phase_d;
      entry_q      <= entry_d;
      ctrl_q       <= ctrl_d;
    end
  end

`ifdef PE_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign start_rdy   = ctrl_q.start_rdy;
  assign busy        = ctrl_q.busy;
  assign in_rdy      = ctrl_q.in_rdy;
  assign actn_in_sel = ctrl_q.actn_in_sel;
  assign wt_in_sel   = ctrl_q.wt_in_sel;
  assign add_in_sel  = ctrl_q.add_in_sel;
  assign pe_out_sel  = ctrl_q.pe_out_sel;
  assign acc_clr     = ctrl_q.acc_clr;
  assign mult_load   = ctrl_q.mult_load;
  assign mult_en     = ctrl_q.mult_en;
  assign add_en      = ctrl_q.add_en;
  assign acc_wr_en   = ctrl_q.acc_wr_en;
  assign of_rf_wr_en = ctrl_q.of_rf_wr_en;
  assign out_vld     = ctrl_q.out_vld;

  // RF writes qualify the registered in_rdy with in_vld so the data is
  // captured in the transfer cycle itself.
  assign if_rf_wr_en = xfer & (state_q == S_LOAD);
  assign wt_rf_wr_en = xfer & ((state_q == S_BIAS_LD) | ~pool_q);

  assign if_rf_rd_en = 1'b0;
  assign wt_rf_rd_en = 1'b0;
  assign of_rf_rd_en = 1'b0;

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with a small PE datapath model and pe_resp stubs.
module tb_pe_ctrl;
  import pe_ctrl_pkg::*;

  localparam int LEN_W   = 8;
  localparam int MUL_LAT = 4;
  localparam int ADD_LAT = 2;

  localparam int M_CLR = 0, M_MLD = 1, M_MEN = 2, M_ADD = 3, M_ACCWR = 4, M_OFWR = 5,
                 M_POOL = 6, M_IFWR = 7, M_WTWR = 8, M_ACC = 9, M_ERR = 10, M_RD = 11,
                 M_NUM = 12;

  logic clk = 1'b0;
  logic rst;
  logic start, start_rdy, cfg_pool, cfg_bias;
  logic [LEN_W-1:0] cfg_len;
  logic in_vld, in_rdy;
  logic actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel;
  logic if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en;
  logic if_rf_rd_en, wt_rf_rd_en, of_rf_rd_en;
  logic mult_en, mult_load, add_en, acc_wr_en, acc_clr;
  logic [1:0] pe_resp;
  logic out_vld, out_rdy, busy, err;

  always #5 clk = ~clk;

  pe_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .start_rdy(start_rdy),
    .cfg_pool(cfg_pool), .cfg_bias(cfg_bias), .cfg_len(cfg_len),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .actn_in_sel(actn_in_sel), .wt_in_sel(wt_in_sel), .add_in_sel(add_in_sel),
    .pe_out_sel(pe_out_sel),
    .if_rf_wr_en(if_rf_wr_en), .wt_rf_wr_en(wt_rf_wr_en), .of_rf_wr_en(of_rf_wr_en),
    .if_rf_rd_en(if_rf_rd_en), .wt_rf_rd_en(wt_rf_rd_en), .of_rf_rd_en(of_rf_rd_en),
    .mult_en(mult_en), .mult_load(mult_load), .add_en(add_en),
    .acc_wr_en(acc_wr_en), .acc_clr(acc_clr),
    .pe_resp(pe_resp), .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy), .err(err)
  );

  // PE datapath model driven by the controller strobes.
  logic [7:0]  actn_in, filt_in, act_rf, wt_rf;
  logic [31:0] mop, sum, acc, pmax, pe_out;
  int          mdly, adly;
  logic        stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_rf <= '0; wt_rf <= '0; mop <= '0; sum <= '0; acc <= '0; pmax <= '0;
      pe_out <= '0; mdly <= 0; adly <= 0; pe_resp <= 2'b00;
    end else begin
      if (if_rf_wr_en) act_rf <= actn_in;
      if (wt_rf_wr_en) wt_rf <= filt_in;
      if (acc_clr) begin acc <= '0; pmax <= '0; end
      if (mult_load) begin mop <= 32'(act_rf) * 32'(wt_rf); pe_resp[0] <= 1'b0; end
      if (mult_en) begin
        mdly <= MUL_LAT; pe_resp[0] <= 1'b0;
      end else if (mdly != 0) begin
        mdly <= mdly - 1;
        if (mdly == 1) pe_resp[0] <= !stall;
      end
      if (add_en) begin
        sum <= acc + (add_in_sel ? 32'(wt_rf) : mop);
        adly <= ADD_LAT; pe_resp[1] <= 1'b0;
      end else if (adly != 0) begin
        adly <= adly - 1;
        if (adly == 1) pe_resp[1] <= !stall;
      end
      if (acc_wr_en) acc <= sum;
      if (actn_in_sel && (32'(act_rf) > pmax)) pmax <= 32'(act_rf);
      if (of_rf_wr_en) pe_out <= pe_out_sel ? pmax : acc;
    end
  end

  // Strobe monitors.
  int   mon [M_NUM] = '{default: 0};
  logic bias_wt_sel, out_sel_at_out;
  always @(posedge clk) begin
    if (acc_clr)     mon[M_CLR]   <= mon[M_CLR] + 1;
    if (mult_load)   mon[M_MLD]   <= mon[M_MLD] + 1;
    if (mult_en)     mon[M_MEN]   <= mon[M_MEN] + 1;
    if (add_en)      mon[M_ADD]   <= mon[M_ADD] + 1;
    if (acc_wr_en)   mon[M_ACCWR] <= mon[M_ACCWR] + 1;
    if (of_rf_wr_en) mon[M_OFWR]  <= mon[M_OFWR] + 1;
    if (actn_in_sel) mon[M_POOL]  <= mon[M_POOL] + 1;
    if (if_rf_wr_en) mon[M_IFWR]  <= mon[M_IFWR] + 1;
    if (wt_rf_wr_en) mon[M_WTWR]  <= mon[M_WTWR] + 1;
    if (start && start_rdy) mon[M_ACC] <= mon[M_ACC] + 1;
    if (err)         mon[M_ERR]   <= mon[M_ERR] + 1;
    if (if_rf_rd_en || wt_rf_rd_en || of_rf_rd_en) mon[M_RD] <= mon[M_RD] + 1;
    if (add_en && add_in_sel) bias_wt_sel <= wt_in_sel;
    if (of_rf_wr_en) out_sel_at_out <= pe_out_sel;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] item_a [0:8];
  logic [7:0] item_w [0:8];
  int d [M_NUM];
  int first_vld, vld_cycles, rdy_seen;

  task automatic run_job(input logic pool, input logic bias, input int len,
                         input int hold, input int gap, input logic keep_start);
    int   base [M_NUM];
    int   idx, nitems;
    logic prev_xfer, hs, done;
    base       = mon;
    nitems     = len + ((bias && !pool) ? 1 : 0);
    idx        = 0;
    prev_xfer  = 1'b0;
    hs         = 1'b0;
    done       = 1'b0;
    first_vld  = -1;
    vld_cycles = 0;
    rdy_seen   = 0;
    @(negedge clk);
    cfg_pool = pool; cfg_bias = bias; cfg_len = LEN_W'(len); start = 1'b1;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (hs) begin
        done = 1'b1; out_rdy = 1'b0; start = 1'b0; in_vld = 1'b0;
      end else begin
        if (c == 0 && !keep_start) start = 1'b0;
        if (prev_xfer) idx++;
        in_vld    = (idx < nitems) && (gap == 0 || (c % gap) == 0);
        actn_in   = item_a[idx];
        filt_in   = item_w[idx];
        prev_xfer = in_vld && in_rdy;
        if (start_rdy) rdy_seen++;
        if (out_vld) begin
          if (first_vld < 0) first_vld = c;
          vld_cycles++;
          out_rdy = (vld_cycles > hold);
          hs      = out_rdy;
        end
      end
    end
    check("job_completed", 32'(done), 32'd1);
    for (int i = 0; i < M_NUM; i++) d[i] = mon[i] - base[i];
  endtask

  task automatic start_stalled_job(output logic ok);
    int   base;
    logic fed;
    ok   = 1'b0;
    fed  = 1'b0;
    base = mon[M_MEN];
    @(negedge clk);
    cfg_pool = 1'b0; cfg_bias = 1'b0; cfg_len = 8'd1; start = 1'b1;
    actn_in = 8'd5; filt_in = 8'd5;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      start  = 1'b0;
      in_vld = !fed;
      if (in_vld && in_rdy) fed = 1'b1;
      ok = (mon[M_MEN] != base);
    end
    in_vld = 1'b0;
  endtask

  logic [13:0] outs_no_rdy;
  assign outs_no_rdy = {busy, in_rdy, actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel,
                        if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en, mult_en, mult_load,
                        add_en, acc_wr_en, acc_clr | out_vld | err};

  initial begin
    logic ok;
    int   of_base, err_c;
    rst = 1'b1; start = 1'b0; cfg_pool = 1'b0; cfg_bias = 1'b0; cfg_len = '0;
    in_vld = 1'b0; out_rdy = 1'b0; stall = 1'b0; actn_in = '0; filt_in = '0;
    for (int i = 0; i < 9; i++) begin item_a[i] = '0; item_w[i] = '0; end
    #12;
    check("reset_start_rdy", 32'(start_rdy), 32'd1);
    check("reset_outputs_zero", 32'(outs_no_rdy), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 1: conv K=3, acts {2,3,4} x wts {5,6,7}
    item_a[0] = 8'd2; item_a[1] = 8'd3; item_a[2] = 8'd4;
    item_w[0] = 8'd5; item_w[1] = 8'd6; item_w[2] = 8'd7;
    run_job(1'b0, 1'b0, 3, 0, 0, 1'b0);
    check("t1_mult_load", 32'(d[M_MLD]), 32'd3);
    check("t1_acc_wr", 32'(d[M_ACCWR]), 32'd3);
    check("t1_acc_clr", 32'(d[M_CLR]), 32'd1);
    check("t1_of_wr", 32'(d[M_OFWR]), 32'd1);
    check("t1_out_vld_rose", 32'(first_vld > 0), 32'd1);
    check("t1_pe_out", pe_out, 32'd56);
    check("t1_idle_after", 32'(start_rdy), 32'd1);

    // 2: conv K=2 with bias 10, acts {1,2} x wts {3,4}
    item_a[0] = 8'd0; item_a[1] = 8'd1; item_a[2] = 8'd2;
    item_w[0] = 8'd10; item_w[1] = 8'd3; item_w[2] = 8'd4;
    run_job(1'b0, 1'b1, 2, 0, 0, 1'b0);
    check("t2_pe_out", pe_out, 32'd21);
    check("t2_bias_wt_sel", 32'(bias_wt_sel), 32'd1);
    check("t2_add_en", 32'(d[M_ADD]), 32'd3);
    check("t2_mult_load", 32'(d[M_MLD]), 32'd2);
    check("t2_acc_wr", 32'(d[M_ACCWR]), 32'd3);

    // 3: pool K=4, acts {3,9,1,7}
    item_a[0] = 8'd3; item_a[1] = 8'd9; item_a[2] = 8'd1; item_a[3] = 8'd7;
    run_job(1'b1, 1'b0, 4, 0, 0, 1'b0);
    check("t3_no_mult", 32'(d[M_MLD] + d[M_MEN]), 32'd0);
    check("t3_no_add", 32'(d[M_ADD]), 32'd0);
    check("t3_pool_cycles", 32'(d[M_POOL]), 32'd4);
    check("t3_if_wr", 32'(d[M_IFWR]), 32'd4);
    check("t3_wt_wr", 32'(d[M_WTWR]), 32'd0);
    check("t3_out_sel", 32'(out_sel_at_out), 32'd1);
    check("t3_pe_out", pe_out, 32'd9);

    // 4: empty window, start held through the job
    run_job(1'b0, 1'b0, 0, 0, 0, 1'b1);
    check("t4_vld_latency", 32'(first_vld), 32'd2);
    check("t4_pe_out", pe_out, 32'd0);
    check("t4_one_accept", 32'(d[M_ACC]), 32'd1);
    check("t4_no_mult", 32'(d[M_MLD]), 32'd0);

    // 5: gapped in_vld, out_rdy held low 5 cycles
    item_a[0] = 8'd1; item_a[1] = 8'd2; item_a[2] = 8'd3;
    item_w[0] = 8'd4; item_w[1] = 8'd5; item_w[2] = 8'd6;
    run_job(1'b0, 1'b0, 3, 5, 3, 1'b0);
    check("t5_if_wr", 32'(d[M_IFWR]), 32'd3);
    check("t5_wt_wr", 32'(d[M_WTWR]), 32'd3);
    check("t5_vld_cycles", 32'(vld_cycles), 32'd6);
    check("t5_start_rdy_low", 32'(rdy_seen), 32'd0);
    check("t5_pe_out", pe_out, 32'd32);
    check("t5_out_vld_dropped", 32'(out_vld), 32'd0);

    // 6: reset while waiting on the multiplier
    stall   = 1'b1;
    of_base = mon[M_OFWR];
    start_stalled_job(ok);
    check("t6_reached_mul_wait", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_outputs_zero", 32'(outs_no_rdy), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("t6_start_rdy", 32'(start_rdy), 32'd1);
    check("t6_no_result", 32'(mon[M_OFWR] - of_base), 32'd0);

`ifdef PE_CTRL_TIMEOUT_EN
    start_stalled_job(ok);
    check("t6w_reached_mul_wait", 32'(ok), 32'd1);
    err_c = -1;
    for (int c = 0; c < 200 && err_c < 0; c++) begin
      @(negedge clk);
      if (err) err_c = c + 1;
    end
    check("t6w_err_cycle", 32'(err_c), 32'd64);
    check("t6w_idle", 32'(start_rdy), 32'd1);
    check("t6w_no_result", 32'(mon[M_OFWR] - of_base), 32'd0);
    @(negedge clk);
    check("t6w_err_pulse", 32'(err), 32'd0);
`else
    check("err_tied_low", 32'(mon[M_ERR]), 32'd0);
`endif
    stall = 1'b0;
    check("rd_en_tied_low", 32'(mon[M_RD]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
